// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data memory arbiter
package dmem_arb_pkg;

    localparam int BURST_CNT_W = 3;
    localparam logic [BURST_CNT_W-1:0] BURST_CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } dmem_arb_state_e;

    typedef enum logic {
        REQ_CORE   = 1'b0,
        REQ_LOADER = 1'b1
    } req_id_t;

endpackage

// File: rtl/dmem_arb_sel.sv
// rtl/dmem_arb_sel.sv - winner selection: core first, loader after MAX_BURST core grants
module dmem_arb_sel
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic                   r0_req,
    input  logic                   r1_req,
    input  logic [BURST_CNT_W-1:0] burst_cnt,
    output logic                   sel_valid,
    output req_id_t                sel_winner
);

    // A limit beyond the counter range behaves as the saturated count.
    localparam logic [BURST_CNT_W-1:0] BURST_LIM =
        (MAX_BURST > int'(BURST_CNT_MAX)) ? BURST_CNT_MAX : BURST_CNT_W'(MAX_BURST);

    logic burst_hit;

    always_comb begin
        burst_hit  = (burst_cnt >= BURST_LIM);
        sel_valid  = r0_req || r1_req;
        sel_winner = REQ_CORE;
        if (r1_req && (!r0_req || burst_hit)) begin
            sel_winner = REQ_LOADER;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester data memory arbiter and access sequencer
// Optional alignment check with per-port error pulse: DMEM_ARB_ALIGN_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r0_gnt,
    output logic              r1_gnt,
    output logic              r0_rvalid,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic [DATA_W-1:0] r1_rdata,
`ifdef DMEM_ARB_ALIGN_EN
    output logic              r0_err,
    output logic              r1_err,
`endif
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wr_dat,
    output logic              rd_en,
    output logic              wr_en,
    input  logic [DATA_W-1:0] m_rd_dat
);

    dmem_arb_state_e        state_q, state_d;
    logic                   we_q, we_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    req_id_t                id_q, id_d;
    logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [DATA_W-1:0]      rdata0_q, rdata0_d;
    logic [DATA_W-1:0]      rdata1_q, rdata1_d;

    logic                   sel_valid;
    req_id_t                sel_winner;
    logic                   acc_ok;
    logic                   resp0;
    logic                   resp1;

    dmem_arb_sel #(
        .MAX_BURST (MAX_BURST)
    ) u_sel (
        .r0_req     (r0_req),
        .r1_req     (r1_req),
        .burst_cnt  (burst_cnt_q),
        .sel_valid  (sel_valid),
        .sel_winner (sel_winner)
    );

`ifdef DMEM_ARB_ALIGN_EN
    assign acc_ok = (addr_q[1:0] == 2'b00);
`else
    assign acc_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            id_q        <= REQ_CORE;
            burst_cnt_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            id_q        <= id_d;
            burst_cnt_q <= burst_cnt_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Writes and rejected accesses need no response phase.
                if (we_q || !acc_ok) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        id_d        = id_q;
        burst_cnt_d = burst_cnt_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        case (state_q)
            IDLE: begin
                if (!r1_req) begin
                    burst_cnt_d = '0;
                end
                if (sel_valid) begin
                    id_d = sel_winner;
                    if (sel_winner == REQ_LOADER) begin
                        we_d    = r1_we;
                        addr_d  = r1_addr;
                        wdata_d = r1_wdata;
                    end else begin
                        we_d    = r0_we;
                        addr_d  = r0_addr;
                        wdata_d = r0_wdata;
                    end
                end
            end
            ISSUE: begin
                // Count core grants only while the loader is kept waiting.
                if (id_q == REQ_LOADER) begin
                    burst_cnt_d = '0;
                end else if (r1_req && (burst_cnt_q != BURST_CNT_MAX)) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (id_q == REQ_LOADER) begin
                    rdata1_d = m_rd_dat;
                end else begin
                    rdata0_d = m_rd_dat;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        r0_gnt    = 1'b0;
        r1_gnt    = 1'b0;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        r0_rvalid = 1'b0;
        r1_rvalid = 1'b0;
`ifdef DMEM_ARB_ALIGN_EN
        r0_err    = 1'b0;
        r1_err    = 1'b0;
`endif
        case (state_q)
            ISSUE: begin
                r0_gnt = (id_q == REQ_CORE);
                r1_gnt = (id_q == REQ_LOADER);
                rd_en  = !we_q && acc_ok;
                wr_en  = we_q && acc_ok;
`ifdef DMEM_ARB_ALIGN_EN
                r0_err = !acc_ok && (id_q == REQ_CORE);
                r1_err = !acc_ok && (id_q == REQ_LOADER);
`endif
            end
            RESP: begin
                r0_rvalid = (id_q == REQ_CORE);
                r1_rvalid = (id_q == REQ_LOADER);
            end
            default: ;
        endcase
    end

    // Read data is forwarded in the response cycle and held afterwards.
    assign resp0    = (state_q == RESP) && (id_q == REQ_CORE);
    assign resp1    = (state_q == RESP) && (id_q == REQ_LOADER);
    assign r0_rdata = resp0 ? m_rd_dat : rdata0_q;
    assign r1_rdata = resp1 ? m_rd_dat : rdata1_q;
    assign m_addr   = addr_q;
    assign m_wr_dat = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        r0_req, r1_req, r0_we, r1_we;
    logic [31:0] r0_addr, r1_addr, r0_wdata, r1_wdata;
    logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [31:0] r0_rdata, r1_rdata;
    logic [31:0] m_addr, m_wr_dat, m_rd_dat;
    logic        rd_en, wr_en;
`ifdef DMEM_ARB_ALIGN_EN
    logic        r0_err, r1_err;
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .reset     (reset),
        .r0_req    (r0_req),
        .r0_we     (r0_we),
        .r0_addr   (r0_addr),
        .r0_wdata  (r0_wdata),
        .r1_req    (r1_req),
        .r1_we     (r1_we),
        .r1_addr   (r1_addr),
        .r1_wdata  (r1_wdata),
        .r0_gnt    (r0_gnt),
        .r1_gnt    (r1_gnt),
        .r0_rvalid (r0_rvalid),
        .r1_rvalid (r1_rvalid),
        .r0_rdata  (r0_rdata),
        .r1_rdata  (r1_rdata),
`ifdef DMEM_ARB_ALIGN_EN
        .r0_err    (r0_err),
        .r1_err    (r1_err),
`endif
        .m_addr    (m_addr),
        .m_wr_dat  (m_wr_dat),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .m_rd_dat  (m_rd_dat)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Memory seen by the DUT, and the reference view the model expects.
    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];

    bit          rq_v     [2];
    bit          rq_we    [2];
    logic [31:0] rq_addr  [2];
    logic [31:0] rq_wdata [2];
    int          mode     [2];   // 0 directed, 1 random, 2 always requesting

    longint      cyc = 0;
    longint      gnt_cyc = -1, rv_cyc = -1, free_cyc = 0;
    int          gnt_id, rv_id;
    bit          gnt_we, gnt_mis;
    logic [31:0] gnt_addr, gnt_wdata, rv_data;
    logic [31:0] exp_rd [2];
    int          cnt;
    bit          in_rst, rel_pending, rd_hold;
    int          gnt_log [$];

    task automatic drive();
        r0_req = rq_v[0]; r0_we = rq_we[0]; r0_addr = rq_addr[0]; r0_wdata = rq_wdata[0];
        r1_req = rq_v[1]; r1_we = rq_we[1]; r1_addr = rq_addr[1]; r1_wdata = rq_wdata[1];
    endtask

    task automatic post(input int i, input bit we, input logic [31:0] addr, input logic [31:0] wd);
        rq_v[i] = 1'b1; rq_we[i] = we; rq_addr[i] = addr; rq_wdata[i] = wd;
    endtask

    task automatic new_req(input int i);
        logic [5:0] w;
        logic [1:0] lo;
        w  = 6'($urandom_range(0, 63));
        lo = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
        post(i, 1'($urandom), {24'h0, w, lo}, $urandom);
    endtask

    task automatic model_clear();
        gnt_cyc = -1; rv_cyc = -1; free_cyc = 0; cnt = 0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        rq_v[0] = 1'b0; rq_v[1] = 1'b0;
        drive();
    endtask

    task automatic step();
        logic [5:0] fl_exp, fl_act;
        logic [5:0] idx;
        @(negedge clk);
        cyc++;
        if (cyc == rv_cyc) exp_rd[rv_id] = rv_data;
        fl_exp = {cyc == gnt_cyc && gnt_id == 0, cyc == gnt_cyc && gnt_id == 1,
                  cyc == gnt_cyc && !gnt_we && !gnt_mis, cyc == gnt_cyc && gnt_we && !gnt_mis,
                  cyc == rv_cyc && rv_id == 0, cyc == rv_cyc && rv_id == 1};
        fl_act = {r0_gnt, r1_gnt, rd_en, wr_en, r0_rvalid, r1_rvalid};
        chk_eq("pulses", fl_act, fl_exp);
`ifdef DMEM_ARB_ALIGN_EN
        chk_eq("err", {r0_err, r1_err},
               {cyc == gnt_cyc && gnt_mis && gnt_id == 0, cyc == gnt_cyc && gnt_mis && gnt_id == 1});
`endif
        chk_eq("rd_wr_excl", rd_en & wr_en, 0);
        chk_eq("gnt_excl", r0_gnt & r1_gnt, 0);
        chk_eq("r0_rdata", r0_rdata, exp_rd[0]);
        chk_eq("r1_rdata", r1_rdata, exp_rd[1]);
        if (cyc == gnt_cyc) begin
            chk_eq("m_addr", m_addr, gnt_addr);
            if (gnt_we) chk_eq("m_wr_dat", m_wr_dat, gnt_wdata);
        end
        if (in_rst) begin
            chk_eq("rst_m_addr", m_addr, 0);
            chk_eq("rst_m_wr_dat", m_wr_dat, 0);
        end
        if (r0_gnt) gnt_log.push_back(0);
        if (r1_gnt) gnt_log.push_back(1);

        // Memory responder: data valid in the cycle after rd_en.
        if (rd_en) begin
            m_rd_dat = mem[m_addr[7:2]];
            rd_hold  = 1'b1;
        end else if (rd_hold) begin
            rd_hold = 1'b0;
        end else begin
            m_rd_dat = $urandom;
        end
        if (wr_en) mem[m_addr[7:2]] = m_wr_dat;

        if (rel_pending) begin
            reset = 1'b1; in_rst = 1'b0; rel_pending = 1'b0; free_cyc = cyc;
        end
        if (cyc == gnt_cyc) rq_v[gnt_id] = 1'b0;
        if (!in_rst) begin
            for (int i = 0; i < 2; i++) begin
                if (!rq_v[i] && (mode[i] == 2 || (mode[i] == 1 && $urandom_range(0, 2) == 0)))
                    new_req(i);
            end
        end
        if (cyc == gnt_cyc) begin
            if (gnt_id == 1) cnt = 0;
            else if (rq_v[1] && cnt < 7) cnt++;
        end
        drive();

        // Arbitration happens on the coming edge when the arbiter is free.
        if (!in_rst && cyc >= free_cyc) begin
            if (!rq_v[1]) cnt = 0;
            if (rq_v[0] || rq_v[1]) begin
                gnt_id    = (rq_v[1] && (!rq_v[0] || cnt >= MB)) ? 1 : 0;
                gnt_we    = rq_we[gnt_id];
                gnt_addr  = rq_addr[gnt_id];
                gnt_wdata = rq_wdata[gnt_id];
                gnt_mis   = ALIGN && (gnt_addr[1:0] != 2'b00);
                gnt_cyc   = cyc + 1;
                idx       = gnt_addr[7:2];
                if (gnt_we && !gnt_mis) ref_mem[idx] = gnt_wdata;
                if (!gnt_we && !gnt_mis) begin
                    rv_cyc   = cyc + 2;
                    rv_id    = gnt_id;
                    rv_data  = ref_mem[idx];
                    free_cyc = cyc + 3;
                end else begin
                    free_cyc = cyc + 2;
                end
            end
        end
    endtask

    task automatic run_until_idle(input int budget);
        int k;
        k = 0;
        while ((rq_v[0] || rq_v[1] || cyc < free_cyc) && k < budget) begin
            step();
            k++;
        end
        chk_eq("drain_timeout", k >= budget, 0);
    endtask

    task automatic sync_reset(input int n);
        reset = 1'b0; in_rst = 1'b1; model_clear();
        repeat (n) step();
        rel_pending = 1'b1;
        step();
    endtask

    initial begin
        logic [31:0] saved;
        int k;
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        m_rd_dat = '0;
        mode[0] = 0; mode[1] = 0;
        for (int i = 0; i < 2; i++) begin
            rq_we[i] = 1'b0; rq_addr[i] = '0; rq_wdata[i] = '0;
        end
        sync_reset(3);

        // Core alone: write then read back.
        post(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        run_until_idle(20);
        post(0, 1'b0, 32'h0000_0010, 32'h0);
        run_until_idle(20);
        chk_eq("t1_rdata", r0_rdata, 32'hDEAD_BEEF);

        // Simultaneous reads: core first, then loader.
        gnt_log.delete();
        post(0, 1'b0, 32'h0000_0020, 32'h0);
        post(1, 1'b0, 32'h0000_0024, 32'h0);
        run_until_idle(20);
        chk_eq("t2_ngnt", gnt_log.size(), 2);
        if (gnt_log.size() == 2) begin
            chk_eq("t2_first", gnt_log[0], 0);
            chk_eq("t2_second", gnt_log[1], 1);
        end
        chk_eq("t2_r0_rdata", r0_rdata, ref_mem[8]);
        chk_eq("t2_r1_rdata", r1_rdata, ref_mem[9]);

        // Starvation bound with both requesting continuously.
        sync_reset(2);
        gnt_log.delete();
        mode[0] = 2; mode[1] = 2;
        k = 0;
        while (gnt_log.size() < 10 && k < 100) begin
            step();
            k++;
        end
        mode[0] = 0; mode[1] = 0;
        run_until_idle(20);
        chk_eq("t3_ngnt", gnt_log.size() >= 10, 1);
        for (int i = 0; i < 10 && i < gnt_log.size(); i++)
            chk_eq("t3_order", gnt_log[i], (i % 5 == 4) ? 1 : 0);

        // Reset asserted during the response cycle of a read.
        post(0, 1'b0, 32'h0000_0030, 32'h0);
        k = 0;
        while (cyc != gnt_cyc && k < 20) begin
            step();
            k++;
        end
        chk_eq("t4_gnt_timeout", k >= 20, 0);
        @(posedge clk);
        #2;
        reset = 1'b0; in_rst = 1'b1; model_clear();
        #1;
        chk_eq("t4_rvalid", r0_rvalid, 0);
        chk_eq("t4_rdata", r0_rdata, 0);
        chk_eq("t4_m_addr", m_addr, 0);
        repeat (3) step();
        rel_pending = 1'b1;
        step();
        post(1, 1'b1, 32'h0000_0040, 32'hA5A5_0001);
        run_until_idle(20);

`ifdef DMEM_ARB_ALIGN_EN
        // Misaligned loader write is granted with an error and not performed.
        saved = mem[1];
        post(1, 1'b1, 32'h0000_0006, 32'h1234_5678);
        run_until_idle(20);
        chk_eq("t5_mem", mem[1], saved);
`else
        saved = '0;
`endif

        // Random traffic from both requesters.
        mode[0] = 1; mode[1] = 1;
        repeat (3000) step();
        mode[0] = 0; mode[1] = 0;
        run_until_idle(20);
        for (int i = 0; i < 64; i++) chk_eq("final_mem", mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
